// File: rtl/conv_pkg.sv
// conv_pkg: types and defaults shared by the line buffer and the convolution kernel.
//   DEF_COLORDEPTH - bits per pixel sample
//   DEF_LINE_END   - line RAM depth (pixels per stored line, power of two)
//   DEF_M_DEPTH    - kernel height (rows presented per clock)
package conv_pkg;

  localparam int unsigned DEF_COLORDEPTH = 8;
  localparam int unsigned DEF_LINE_END   = 2048;
  localparam int unsigned DEF_M_DEPTH    = 3;

  typedef logic [DEF_COLORDEPTH-1:0] pixel_t;

  // Address width for a memory of 'depth' entries (at least one bit).
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_ram.sv
// line_ram: single-port, read-first line memory with registered read data.
//   clk  - clock
//   we   - write enable
//   addr - shared read/write address
//   d    - write data
//   q    - data stored at addr before this cycle's write, one cycle later
// The array has no reset so it maps onto block RAM.
module line_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] q_q;

  // Read-first: q_q samples the old contents in the same cycle as the write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= d;
    end
    q_q <= mem_q[addr];
  end

  assign q = q_q;

endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: turns one raster pixel stream into M_DEPTH vertically
// aligned pixels per clock (current row plus the rows above), 2-cycle latency.
//   clk, rst   - clock, asynchronous active-high reset
//   px_i       - input pixel, valid with dv_i
//   dv_i/hs_i/vs_i - input timing; vs_i low clears frame state
//   vect_o     - [0] current row, [k] k rows above, all at the same column
//   dv_o/hs_o/vs_o - input timing delayed 2 cycles
//   line_end_o - one-cycle pulse after the falling edge of dv_o
// The RAM chain reaches row k+1 above after k+1 cycles, so exact column
// alignment holds for M_DEPTH of 2 or 3.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned COLORDEPTH = DEF_COLORDEPTH,
  parameter int unsigned LINE_END   = DEF_LINE_END,
  parameter int unsigned M_DEPTH    = DEF_M_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [COLORDEPTH-1:0]                px_i,
  input  logic                                 dv_i,
  input  logic                                 hs_i,
  input  logic                                 vs_i,
  output logic [M_DEPTH-1:0][COLORDEPTH-1:0]   vect_o,
  output logic                                 dv_o,
  output logic                                 hs_o,
  output logic                                 vs_o,
  output logic                                 line_end_o
);

  localparam int unsigned AW   = addr_w(LINE_END);
  localparam int unsigned RW   = addr_w(M_DEPTH);
  localparam int unsigned NRAM = M_DEPTH - 1;
  localparam int unsigned NDLY = (M_DEPTH > 2) ? M_DEPTH - 2 : 1;

  localparam logic [AW-1:0] COL_LAST = AW'(LINE_END - 1);
  localparam logic [RW-1:0] ROWS_MAX = RW'(M_DEPTH - 1);

  logic [AW-1:0]                   col_q, col_d;
  logic                            ovf_q, ovf_d;
  logic [RW-1:0]                   rows_q, rows_d;
  logic [1:0]                      dv_sr_q, dv_sr_d;
  logic [1:0]                      hs_sr_q, hs_sr_d;
  logic [1:0]                      vs_sr_q, vs_sr_d;
  logic                            dv_o_dly_q, dv_o_dly_d;
  logic                            line_end_q, line_end_d;
  logic [COLORDEPTH-1:0]           px_d1_q, px_d1_d;
  logic [M_DEPTH-1:0]              mask_d1_q, mask_d1_d;
  logic [NDLY-1:0]                 mask_d2_q, mask_d2_d;
  logic [1:0][COLORDEPTH-1:0]      vect_q, vect_d;
  logic [NDLY-1:0][AW-1:0]         addr_dly_q, addr_dly_d;
  logic [NDLY-1:0]                 we_dly_q, we_dly_d;

  logic                            wr_ok;
  logic [NRAM-1:0][AW-1:0]         ram_addr;
  logic [NRAM-1:0]                 ram_we;
  logic [NRAM-1:0][COLORDEPTH-1:0] ram_d;
  logic [NRAM-1:0][COLORDEPTH-1:0] ram_q;

  // Column / row tracking, timing delay lines and per-pixel tap masks.
  always_comb begin
    col_d      = col_q;
    ovf_d      = ovf_q;
    rows_d     = rows_q;
    dv_sr_d    = {dv_sr_q[0], dv_i};
    hs_sr_d    = {hs_sr_q[0], hs_i};
    vs_sr_d    = {vs_sr_q[0], vs_i};
    dv_o_dly_d = dv_sr_q[1];
    line_end_d = dv_o_dly_q & ~dv_sr_q[1];
    px_d1_d    = px_i;
    mask_d1_d  = '0;
    mask_d2_d  = '0;
    vect_d     = '0;
    addr_dly_d = addr_dly_q;
    we_dly_d   = we_dly_q;

    // Pixels past the last RAM address are neither stored nor shown above row 0.
    wr_ok = dv_i & ~ovf_q;

    if (!vs_i || !dv_i) begin
      col_d = '0;
      ovf_d = 1'b0;
    end else if (col_q == COL_LAST) begin
      ovf_d = 1'b1;
    end else begin
      col_d = col_q + AW'(1);
    end

    // A dv_i falling edge (even a one-cycle gap) ends a line.
    if (!vs_i) begin
      rows_d = '0;
    end else if (dv_sr_q[0] && !dv_i && (rows_q != ROWS_MAX)) begin
      rows_d = rows_q + RW'(1);
    end

    // Tap k is live only once k lines of this frame have been stored.
    mask_d1_d[0] = dv_i;
    for (int unsigned k = 1; k < M_DEPTH; k++) begin
      mask_d1_d[k] = dv_i && !ovf_q && (rows_q >= RW'(k));
    end
    for (int unsigned k = 2; k < M_DEPTH; k++) begin
      mask_d2_d[k-2] = mask_d1_q[k];
    end

    vect_d[0] = mask_d1_q[0] ? px_d1_q  : '0;
    vect_d[1] = mask_d1_q[1] ? ram_q[0] : '0;

    // RAM k sees the column and write enable k cycles late, matching its data.
    addr_dly_d[0] = col_q;
    we_dly_d[0]   = wr_ok;
    for (int unsigned j = 1; j < NDLY; j++) begin
      addr_dly_d[j] = addr_dly_q[j-1];
      we_dly_d[j]   = we_dly_q[j-1];
    end
  end

  // RAM chain wiring: RAM0 takes the live pixel, RAM k the read data of RAM k-1.
  always_comb begin
    ram_addr    = '0;
    ram_we      = '0;
    ram_d       = '0;
    ram_addr[0] = col_q;
    ram_we[0]   = wr_ok;
    ram_d[0]    = px_i;
    for (int unsigned k = 1; k < NRAM; k++) begin
      ram_addr[k] = addr_dly_q[k-1];
      ram_we[k]   = we_dly_q[k-1];
      ram_d[k]    = ram_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      ovf_q      <= 1'b0;
      rows_q     <= '0;
      dv_sr_q    <= '0;
      hs_sr_q    <= '0;
      vs_sr_q    <= '0;
      dv_o_dly_q <= 1'b0;
      line_end_q <= 1'b0;
      px_d1_q    <= '0;
      mask_d1_q  <= '0;
      mask_d2_q  <= '0;
      vect_q     <= '0;
      addr_dly_q <= '0;
      we_dly_q   <= '0;
    end else begin
      col_q      <= col_d;
      ovf_q      <= ovf_d;
      rows_q     <= rows_d;
      dv_sr_q    <= dv_sr_d;
      hs_sr_q    <= hs_sr_d;
      vs_sr_q    <= vs_sr_d;
      dv_o_dly_q <= dv_o_dly_d;
      line_end_q <= line_end_d;
      px_d1_q    <= px_d1_d;
      mask_d1_q  <= mask_d1_d;
      mask_d2_q  <= mask_d2_d;
      vect_q     <= vect_d;
      addr_dly_q <= addr_dly_d;
      we_dly_q   <= we_dly_d;
    end
  end

  for (genvar g = 0; g < NRAM; g++) begin : g_ram
    line_ram #(
      .WIDTH (COLORDEPTH),
      .DEPTH (LINE_END)
    ) u_line_ram (
      .clk  (clk),
      .we   (ram_we[g]),
      .addr (ram_addr[g]),
      .d    (ram_d[g]),
      .q    (ram_q[g])
    );
  end

  // Taps two or more rows up come straight off the RAM output register, gated
  // by a mask flop that was reset together with the rest of the pipeline.
  always_comb begin
    vect_o    = '0;
    vect_o[0] = vect_q[0];
    vect_o[1] = vect_q[1];
    for (int unsigned k = 2; k < M_DEPTH; k++) begin
      vect_o[k] = mask_d2_q[k-2] ? ram_q[k-1] : '0;
    end
  end

  assign dv_o       = dv_sr_q[1];
  assign hs_o       = hs_sr_q[1];
  assign vs_o       = vs_sr_q[1];
  assign line_end_o = line_end_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// tb_conv_line_buffer: directed bench for conv_line_buffer (LINE_END=8, M_DEPTH=3).
module tb_conv_line_buffer;
  import conv_pkg::*;

  localparam int unsigned CD = 8;
  localparam int unsigned LE = 8;
  localparam int unsigned MD = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [CD-1:0]          px_i;
  logic                   dv_i, hs_i, vs_i;
  logic [MD-1:0][CD-1:0]  vect_o;
  logic                   dv_o, hs_o, vs_o, line_end_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the previous step's inputs, plus dv input history.
  logic [23:0] exp_prev;
  logic        dv_h1, dv_h2, dv_h3, hs_h1, vs_h1;

  conv_line_buffer #(
    .COLORDEPTH (CD),
    .LINE_END   (LE),
    .M_DEPTH    (MD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .px_i       (px_i),
    .dv_i       (dv_i),
    .hs_i       (hs_i),
    .vs_i       (vs_i),
    .vect_o     (vect_o),
    .dv_o       (dv_o),
    .hs_o       (hs_o),
    .vs_o       (vs_o),
    .line_end_o (line_end_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vect"},     vect_o,            24'h0);
    check({tag, "_dv_o"},     24'(dv_o),         24'h0);
    check({tag, "_hs_o"},     24'(hs_o),         24'h0);
    check({tag, "_vs_o"},     24'(vs_o),         24'h0);
    check({tag, "_line_end"}, 24'(line_end_o),   24'h0);
  endtask

  task automatic clear_hist();
    exp_prev = 24'h0;
    dv_h1 = 1'b0; dv_h2 = 1'b0; dv_h3 = 1'b0;
    hs_h1 = 1'b0; vs_h1 = 1'b0;
  endtask

  // Apply one cycle of input; ev is the vect_o expected two cycles later.
  // After the edge the outputs reflect the previous step's inputs.
  task automatic step(input logic dv, input logic hs, input logic vs,
                      input logic [7:0] px, input logic [23:0] ev);
    dv_i = dv; hs_i = hs; vs_i = vs; px_i = px;
    @(posedge clk);
    #1;
    check("vect",     vect_o,          exp_prev);
    check("dv_o",     24'(dv_o),       24'(dv_h1));
    check("hs_o",     24'(hs_o),       24'(hs_h1));
    check("vs_o",     24'(vs_o),       24'(vs_h1));
    check("line_end", 24'(line_end_o), 24'(~dv_h2 & dv_h3));
    dv_h3 = dv_h2; dv_h2 = dv_h1; dv_h1 = dv;
    hs_h1 = hs; vs_h1 = vs;
    exp_prev = ev;
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, vs, 8'h00, 24'h0);
    end
  endtask

  // Line of n pixels b0+c; taps 1/2 expected as b1+c / b2+c when u1/u2 set
  // and the column was stored (c < LE).
  task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic u1, input logic u2);
    logic [23:0] ev;
    for (int c = 0; c < n; c++) begin
      ev[7:0]   = 8'(b0 + 8'(c));
      ev[15:8]  = (u1 && c < int'(LE)) ? 8'(b1 + 8'(c)) : 8'h00;
      ev[23:16] = (u2 && c < int'(LE)) ? 8'(b2 + 8'(c)) : 8'h00;
      step(1'b1, 1'b0, 1'b1, 8'(b0 + 8'(c)), ev);
    end
  endtask

  initial begin
    rst = 1'b1; px_i = '0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    clear_hist();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_init");
    rst = 1'b0;
    idle(2, 1'b0);

    // Asynchronous reset in the middle of a line.
    idle(1, 1'b1);
    send_line(3, 8'h90, 8'h00, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    px_i = '0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    rst = 1'b0;
    clear_hist();
    idle(3, 1'b0);

    // Frame fill: value = row*16 + col.
    idle(1, 1'b1);
    send_line(4, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(2, 1'b1);
    send_line(4, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0);
    idle(2, 1'b1);
    send_line(4, 8'h20, 8'h10, 8'h00, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Frame restart: one cycle of vs_i low hides all previous-frame rows.
    idle(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'hFF, 24'h0000FF);
    end
    idle(3, 1'b1);

    // Timing alignment with independent hs/vs/dv patterns.
    step(1'b0, 1'b1, 1'b0, 8'h00, 24'h000000);
    step(1'b0, 1'b0, 1'b0, 8'h00, 24'h000000);
    step(1'b1, 1'b0, 1'b0, 8'h31, 24'h000031);
    step(1'b0, 1'b1, 1'b0, 8'h00, 24'h000000);
    step(1'b0, 1'b1, 1'b1, 8'h00, 24'h000000);
    step(1'b1, 1'b0, 1'b1, 8'h32, 24'h000032);
    step(1'b1, 1'b1, 1'b1, 8'h33, 24'h000033);
    step(1'b0, 1'b0, 1'b1, 8'h00, 24'h000000);
    step(1'b0, 1'b1, 1'b0, 8'h00, 24'h000000);
    idle(4, 1'b0);

    // Line overflow: 10-pixel lines into an 8-entry line RAM.
    idle(1, 1'b1);
    send_line(10, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(2, 1'b1);
    send_line(10, 8'h50, 8'h40, 8'h00, 1'b1, 1'b0);
    idle(2, 1'b1);
    send_line(10, 8'h60, 8'h50, 8'h40, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Single-cycle dv gap counts as a line end.
    idle(1, 1'b0);
    idle(1, 1'b1);
    send_line(3, 8'h70, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(1, 1'b1);
    send_line(3, 8'h80, 8'h70, 8'h00, 1'b1, 1'b0);
    idle(4, 1'b1);
    idle(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
- Pixel-stream producer for the convolution stage. Takes a single raster pixel stream with dv/hs/vs timing and emits M_DEPTH vertically aligned pixels per clock: the current row plus the M_DEPTH-1 rows above it.
- Re-times dv/hs/vs by the same latency so downstream timing stays aligned.
- Sits between the video input timing path and the convolution kernel; its vect_o feeds the kernel's vect_in directly.

Parameters:
- COLORDEPTH, 8, bits per pixel sample.
- LINE_END, 2048, line RAM depth; maximum pixels stored per line. Must be a power of two.
- M_DEPTH, 3, number of rows presented (kernel height, ≥2).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- px_i  in  COLORDEPTH  input pixel, valid when dv_i=1.
- dv_i  in  1  data valid (active video).
- hs_i  in  1  horizontal sync, passed through.
- vs_i  in  1  vertical sync/frame active; low clears frame state.
- vect_o  out  COLORDEPTH x M_DEPTH  index 0 = current row, index k = k rows above.
- dv_o  out  1  dv_i delayed 2 cycles.
- hs_o  out  1  hs_i delayed 2 cycles.
- vs_o  out  1  vs_i delayed 2 cycles.
- line_end_o  out  1  one-cycle pulse on the falling edge of dv_o.

Behaviour:
- Reset (async, rst=1): all outputs 0; column counter, row counter, delay registers and edge detector 0. RAM contents are not cleared.
- Column counter col, clog2(LINE_END) bits:
  - Increments on each dv_i=1 cycle.
  - Returns to 0 on the cycle after dv_i falls.
  - Held at 0 while vs_i=0.
  - Saturates at LINE_END-1. Pixels beyond that point are not written, and their vect_o[k>0] are 0.
- Line RAM chain: M_DEPTH-1 instances of line_ram, single-port, read-first.
  - RAM0: write px_i at col when dv_i=1. The read of the same address returns the previous-row pixel, registered as q0 one cycle later.
  - RAMk (k≥1): write q(k-1) at col delayed k cycles, with write enable dv_i delayed k cycles. Read data returns the pixel k+1 rows above.
- Alignment: total latency is exactly 2 cycles from px_i to vect_o.
  - vect_o[0] = px_i delayed 2.
  - vect_o[k] = RAM(k-1) output delayed by (2 - pipeline depth), so all indices refer to the same column.
  - dv/hs/vs use 2-stage shift registers.
- Row counter rows, saturating at M_DEPTH-1:
  - Increments on each dv_i falling edge while vs_i=1.
  - Cleared when vs_i=0.
  - vect_o[k] is forced to 0 while rows < k. No stale data from the previous frame is emitted.
- vect_o is 0 whenever dv_o=0.
- line_end_o = dv_o delayed 1 cycle AND NOT dv_o, registered. Pulse width is 1 cycle.
- Boundary cases:
  - vs_i falling mid-line: col and rows clear the next cycle. Outputs already in the pipe drain normally.
  - dv_i=0 for a single cycle inside a line counts as a line end.
  - rst mid-frame: state is cleared immediately. The first post-reset frame behaves as frame start (rows=0).
- Arithmetic: no signed data; pixels are passed through unmodified, zero-extended nowhere.

Decomposition:
- Package conv_pkg:
  - pixel_t typedef (logic [COLORDEPTH-1:0]).
  - Default COLORDEPTH, LINE_END and M_DEPTH constants, shared with the convolution kernel.
  - Function addr_w = clog2(LINE_END).
- Sub-module line_ram: single-port, read-first, registered read.
  - Parameters WIDTH and DEPTH.
  - Ports clk, we, addr, d, q.
  - No reset on the array; infers BRAM.

Test Plan:
1. Reset behaviour: assert rst=1 asynchronously mid-stream -> all outputs 0 immediately, without waiting for a clk edge. After release with vs_i=0, outputs stay 0.
2. Frame fill: set vs_i=1, then 3 lines of 4 pixels with value=row*16+col, separated by 2 idle cycles. Required response:
   - Line 0: vect_o = {0,0,px}.
   - Line 1, col 2: vect_o = {0,0x02,0x12}.
   - Line 2, col 3: {0x03,0x13,0x23}.
   - Each pixel appears 2 cycles after input.
3. Timing alignment: hs_i/vs_i/dv_i pulse patterns -> identical patterns on hs_o/vs_o/dv_o delayed exactly 2 cycles. line_end_o is high exactly 1 cycle, 3 cycles after the dv_i falling edge.
4. Frame restart: fill 3 lines, drop vs_i for 1 cycle, start a new line of 0xFF -> vect_o = {0,0,0xFF}, with no previous-frame data visible.
5. Line overflow: with LINE_END=8, drive a 10-pixel line then a second line -> second-line cols 0-7 show the correct row above; cols 8-9 show vect_o[1]=0. No RAM wraparound corruption appears in line 3.
6. Single-cycle dv gap: a dv_i=0 cycle mid-line -> treated as a line end. rows increments, col restarts at 0, and line_end_o pulses once.
